// File: rtl/horner_poly_eval.sv
// Polynomial evaluator using Horner's method with one multiplier and one adder.
// The operands are latched at start. Each coefficient step takes one MUL cycle
// and one ADD cycle. Wrap-around in the multiplier or the adder sets a sticky
// overflow flag.
module horner_poly_eval #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEGREE = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inicio,
  input  logic [(DEGREE+1)*WIDTH-1:0] coef,
  input  logic [WIDTH-1:0]            x,
  output logic [WIDTH-1:0]            saida,
  output logic                        pronto,
  output logic                        ocupado,
  output logic                        overflow
);

  localparam int unsigned IDX_W     = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1);
  localparam int unsigned DEPTH     = 2 ** IDX_W;
  localparam int unsigned IDX_START = (DEGREE > 0) ? DEGREE - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     coef_q [DEPTH];
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     prod;
  logic [IDX_W-1:0]     idx;

  logic [2*WIDTH-1:0]   prod_full_c;
  logic [WIDTH:0]       sum_c;

  // Shared datapath: full-width product and carry-extended sum
  assign prod_full_c = (2*WIDTH)'(acc) * (2*WIDTH)'(x_q);
  assign sum_c       = {1'b0, prod} + {1'b0, coef_q[idx]};

  // Control FSM with registered datapath and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      saida    <= '0;
      pronto   <= 1'b0;
      ocupado  <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      prod     <= '0;
      idx      <= '0;
      x_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      pronto <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inicio) begin
            x_q <= x;
            for (int unsigned i = 0; i <= DEGREE; i++) begin
              coef_q[IDX_W'(i)] <= coef[i*WIDTH +: WIDTH];
            end
            overflow <= 1'b0;
            ocupado  <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc <= coef_q[IDX_W'(DEGREE)];
          idx <= IDX_W'(IDX_START);
          if (DEGREE == 0) begin
            // Constant polynomial: the result is simply c_0
            saida  <= coef_q[0];
            pronto <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod <= prod_full_c[WIDTH-1:0];
          if (|prod_full_c[2*WIDTH-1:WIDTH]) begin
            overflow <= 1'b1;
          end
          state <= S_ADD;
        end
        S_ADD: begin
          acc <= sum_c[WIDTH-1:0];
          if (sum_c[WIDTH]) begin
            overflow <= 1'b1;
          end
          if (idx == '0) begin
            saida  <= sum_c[WIDTH-1:0];
            pronto <= 1'b1;
            state  <= S_DONE;
          end else begin
            idx   <= idx - 1'b1;
            state <= S_MUL;
          end
        end
        S_DONE: begin
          ocupado <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          ocupado <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/horner_poly_eval.md
HORNER_POLY_EVAL -- requirements
Module: horner_poly_eval

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: data width of x, every coefficient and the result.
REQ-002 SHALL provide parameter DEGREE, default 2: polynomial degree, legal range 0..15.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port inicio, input, 1 bit: start request, sampled only in IDLE.
REQ-006 SHALL provide port coef, input, (DEGREE+1)*WIDTH bits: packed coefficients; c_i = coef[WIDTH*(i+1)-1 : WIDTH*i].
REQ-007 SHALL provide port x, input, WIDTH bits: evaluation point.
REQ-008 SHALL provide port saida, output, WIDTH bits: registered result, c_D*x^D + ... + c_1*x + c_0 mod 2^WIDTH.
REQ-009 SHALL provide port pronto, output, 1 bit: one-cycle done pulse.
REQ-010 SHALL provide port ocupado, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL provide port overflow, output, 1 bit: sticky flag for the current or last evaluation.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, MUL, ADD, DONE, using Horner's method with one multiplier and one adder.
REQ-013 IDLE, inicio=1 at an edge: latch x and all coefficients into internal registers, clear overflow, go to LOAD; inputs may change afterwards without effect.
REQ-014 IDLE, inicio=0: remain in IDLE; saida and overflow hold their values.
REQ-015 LOAD: acc <= c_DEGREE; idx <= DEGREE-1; go to MUL, or to DONE with saida <= c_0 when DEGREE=0.
REQ-016 MUL: prod <= low WIDTH bits of acc*x; set overflow if any upper WIDTH bits of the full 2*WIDTH product are nonzero; go to ADD.
REQ-017 ADD: acc <= (prod + c_idx) mod 2^WIDTH; set overflow on carry out.
REQ-018 ADD with idx=0: saida <= new acc value; go to DONE.
REQ-019 ADD with idx≠0: idx <= idx-1; go to MUL.
REQ-020 DONE: pronto=1 for exactly this one cycle; go to IDLE unconditionally.
REQ-021 Latency: pronto SHALL be high in the cycle following the (2*DEGREE+1)th rising edge after the edge that sampled inicio (DEGREE=2 -> 5 edges).
REQ-022 A new start SHALL be accepted no earlier than the edge after DONE; back-to-back operation gives a period of 2*DEGREE+3 cycles.
REQ-023 inicio asserted while ocupado=1 SHALL be ignored; it is not queued.
REQ-024 saida SHALL change only at the final ADD edge (or at LOAD when DEGREE=0) and hold until the next completion.
REQ-025 overflow, once set, SHALL remain high until the next accepted start or reset.
REQ-026 Arithmetic is unsigned, modulo 2^WIDTH.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE with saida=0, pronto=0, ocupado=0, overflow=0, acc=0, prod=0, idx=0.
REQ-028 reset SHALL take priority over inicio and over any in-progress state, including mid-operation; no pronto pulse follows an aborted evaluation.
REQ-029 Outputs SHALL stay at reset values while reset is held high.

Verification
REQ-030 WIDTH=16, DEGREE=2, c2=3, c1=2, c0=3, x=3, one-cycle inicio pulse -> pronto high 5 edges later for one cycle; saida=36; overflow=0; ocupado high for exactly 6 cycles.
REQ-031 WIDTH=8, DEGREE=2, c2=1, c1=0, c0=5, x=16 -> saida=5 (261 mod 256); overflow=1 held until the next start.
REQ-032 DEGREE=0, c0=0x1234 -> pronto after 1 edge; saida=0x1234.
REQ-033 Reset asserted at the 3rd edge of an evaluation -> next cycle ocupado=0, saida=0, overflow=0; no pronto pulse; a subsequent start completes correctly.
REQ-034 inicio held high continuously, with x changed mid-operation -> results use x latched at each accepted start; pronto pulses every 2*DEGREE+3 cycles; saida changes only at completions.
